conversor_bin_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter that processes one input bit per clock with the shift-and-add-3 (double dabble) method. It replaces the fully unrolled 8-bit / 3-digit combinational converter where wider operands or more digits make an unrolled array too large. It sits between the arithmetic datapath and the 7-segment display drivers, and uses a start/done handshake.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/ajuste_bcd_digito.sv | 17 +
 rtl/conversor_bin_bcd_seq.sv | 155 +++++++++++++++
 tb/tb_conversor_bin_bcd_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_LIMIAR = 4'd5;
    localparam logic [BCD_W-1:0] BCD_AJUSTE = 4'd3;

    typedef enum logic {
        OCIOSO   = 1'b0,
        CONVERTE = 1'b1
    } estado_t;

endpackage

// File: rtl/ajuste_bcd_digito.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module ajuste_bcd_digito
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digito,
    output logic [BCD_W-1:0] ajustado_c
);

    // Correction wraps in 4 bits; the carry is recovered by the following shift.
    always_comb begin
        ajustado_c = digito;
        if (digito >= BCD_LIMIAR) begin
            ajustado_c = BCD_W'(digito + BCD_AJUSTE);
        end
    end

endmodule

// File: rtl/conversor_bin_bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock (double dabble).
// Optional leading-zero blank mask port `apagado` under BCD_APAGA_ZEROS_EN.
module conversor_bin_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned LARG  = 8,
    parameter int unsigned N_DIG = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [LARG-1:0]        bin_in,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [BCD_W*N_DIG-1:0] bcd_out,
    output logic                   estouro
`ifdef BCD_APAGA_ZEROS_EN
    ,
    output logic [N_DIG-1:0]       apagado
`endif
);

    localparam int unsigned CNT_W   = $clog2(LARG + 1);
    localparam int unsigned TOTAL_W = BCD_W * N_DIG;

    estado_t             estado;
    estado_t             estado_nxt;
    logic [LARG-1:0]     desloc;
    logic [TOTAL_W-1:0]  digitos;
    logic [TOTAL_W-1:0]  ajustados;
    logic [TOTAL_W-1:0]  digitos_nxt;
    logic                acum;
    logic [CNT_W-1:0]    cont;
    logic                saida;
    logic                carrega;
    logic                passo;
    logic                fim;
    logic                ocupado_nxt;
    logic                pronto_nxt;

    // One corrector per digit of the chain.
    for (genvar g = 0; g < int'(N_DIG); g++) begin : g_ajuste
        ajuste_bcd_digito u_ajuste (
            .digito     (digitos[g*BCD_W +: BCD_W]),
            .ajustado_c (ajustados[g*BCD_W +: BCD_W])
        );
    end

    // Shift the corrected chain left, operand MSB entering units bit 0.
    assign digitos_nxt = {ajustados[TOTAL_W-2:0], desloc[LARG-1]};
    assign saida       = ajustados[TOTAL_W-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Next state and datapath controls.
    always_comb begin
        estado_nxt  = estado;
        carrega     = 1'b0;
        passo       = 1'b0;
        fim         = 1'b0;
        ocupado_nxt = 1'b0;
        pronto_nxt  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    estado_nxt  = CONVERTE;
                    carrega     = 1'b1;
                    ocupado_nxt = 1'b1;
                end
            end
            CONVERTE: begin
                passo = 1'b1;
                if (cont == CNT_W'(1)) begin
                    fim        = 1'b1;
                    pronto_nxt = 1'b1;
                    estado_nxt = OCIOSO;
                end else begin
                    ocupado_nxt = 1'b1;
                end
            end
            default: estado_nxt = OCIOSO;
        endcase
    end

    // Working registers: operand shifter, digit chain, overflow accumulator, step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desloc  <= '0;
            digitos <= '0;
            acum    <= 1'b0;
            cont    <= '0;
        end else if (carrega) begin
            desloc  <= bin_in;
            digitos <= '0;
            acum    <= 1'b0;
            cont    <= CNT_W'(LARG);
        end else if (passo) begin
            desloc  <= desloc << 1;
            digitos <= digitos_nxt;
            acum    <= acum | saida;
            cont    <= cont - CNT_W'(1);
        end
    end

    // Handshake and result registers; results move only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocupado <= 1'b0;
            pronto  <= 1'b0;
            bcd_out <= '0;
            estouro <= 1'b0;
        end else begin
            ocupado <= ocupado_nxt;
            pronto  <= pronto_nxt;
            if (fim) begin
                bcd_out <= digitos_nxt;
                estouro <= acum | saida;
            end
        end
    end

`ifdef BCD_APAGA_ZEROS_EN
    localparam logic [N_DIG-1:0] APAGA_RST = ~N_DIG'(1);

    logic [N_DIG-1:0] mascara_nxt;
    logic             zeros_acima;

    // Blank digit i when it and every higher digit are zero; units never blank.
    always_comb begin
        mascara_nxt = '0;
        zeros_acima = 1'b1;
        for (int i = int'(N_DIG) - 1; i >= 1; i--) begin
            zeros_acima    = zeros_acima & (digitos_nxt[i*BCD_W +: BCD_W] == '0);
            mascara_nxt[i] = zeros_acima;
        end
    end

    // Blank mask registered alongside bcd_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apagado <= APAGA_RST;
        end else if (fim) begin
            apagado <= mascara_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// Directed bench for conversor_bin_bcd_seq: default, 2-digit and 12-bit/4-digit builds.
module tb_conversor_bin_bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Default instance: LARG=8, N_DIG=3
    logic        ini1 = 1'b0;
    logic [7:0]  bin1 = '0;
    logic        ocu1, pro1, est1;
    logic [11:0] bcd1;
    logic [2:0]  apa1;

    // Two-digit instance for overflow
    logic        ini2 = 1'b0;
    logic [7:0]  bin2 = '0;
    logic        ocu2, pro2, est2;
    logic [7:0]  bcd2;
    logic [1:0]  apa2;

    // Wide instance: LARG=12, N_DIG=4
    logic        ini3 = 1'b0;
    logic [11:0] bin3 = '0;
    logic        ocu3, pro3, est3;
    logic [15:0] bcd3;
    logic [3:0]  apa3;

    conversor_bin_bcd_seq #(.LARG(8), .N_DIG(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .inicio(ini1), .bin_in(bin1),
        .ocupado(ocu1), .pronto(pro1), .bcd_out(bcd1), .estouro(est1)
`ifdef BCD_APAGA_ZEROS_EN
        , .apagado(apa1)
`endif
    );

    conversor_bin_bcd_seq #(.LARG(8), .N_DIG(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .inicio(ini2), .bin_in(bin2),
        .ocupado(ocu2), .pronto(pro2), .bcd_out(bcd2), .estouro(est2)
`ifdef BCD_APAGA_ZEROS_EN
        , .apagado(apa2)
`endif
    );

    conversor_bin_bcd_seq #(.LARG(12), .N_DIG(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .inicio(ini3), .bin_in(bin3),
        .ocupado(ocu3), .pronto(pro3), .bcd_out(bcd3), .estouro(est3)
`ifdef BCD_APAGA_ZEROS_EN
        , .apagado(apa3)
`endif
    );

`ifndef BCD_APAGA_ZEROS_EN
    assign apa1 = '0;
    assign apa2 = '0;
    assign apa3 = '0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_total++;
        if (atual === esperado) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [2:0]  apag;
    } vet_t;

    vet_t tab[8];

    // Wait (bounded) for pronto on instance 1; returns cycles after E0 and busy-cycle count.
    task automatic espera1(output int ciclos, output int ocupados);
        ciclos   = 0;
        ocupados = 0;
        while (!pro1 && ciclos < 30) begin
            if (ocu1) ocupados++;
            ciclos++;
            @(negedge clk);
        end
    endtask

    // Start instance 1 at the next rising edge (E0); returns at the first negedge after E0.
    task automatic inicia1(input logic [7:0] v);
        bin1 = v;
        ini1 = 1'b1;
        @(negedge clk);
        ini1 = 1'b0;
    endtask

    task automatic conv1(input string nome, input logic [7:0] v, input logic [11:0] exp_bcd,
                         input logic [2:0] exp_apag);
        int c, o;
        @(negedge clk);
        inicia1(v);
        espera1(c, o);
        chk({nome, " latency"}, 32'(c), 32'd8);
        chk({nome, " busy"}, 32'(o), 32'd8);
        chk({nome, " pronto/ocupado"}, {30'd0, pro1, ocu1}, 32'b10);
        chk({nome, " bcd"}, 32'(bcd1), 32'(exp_bcd));
        chk({nome, " estouro"}, 32'(est1), 32'd0);
`ifdef BCD_APAGA_ZEROS_EN
        chk({nome, " apagado"}, 32'(apa1), 32'(exp_apag));
`endif
        @(negedge clk);
        chk({nome, " pulse"}, 32'(pro1), 32'd0);
    endtask

    task automatic conv2(input string nome, input logic [7:0] v, input logic [7:0] exp_bcd,
                         input logic exp_est);
        int c;
        @(negedge clk);
        bin2 = v;
        ini2 = 1'b1;
        @(negedge clk);
        ini2 = 1'b0;
        c = 0;
        while (!pro2 && c < 30) begin
            c++;
            @(negedge clk);
        end
        chk({nome, " latency"}, 32'(c), 32'd8);
        chk({nome, " bcd"}, 32'(bcd2), 32'(exp_bcd));
        chk({nome, " estouro"}, 32'(est2), 32'(exp_est));
    endtask

    task automatic conv3(input string nome, input logic [11:0] v, input logic [15:0] exp_bcd);
        int c;
        @(negedge clk);
        bin3 = v;
        ini3 = 1'b1;
        @(negedge clk);
        ini3 = 1'b0;
        c = 0;
        while (!pro3 && c < 40) begin
            c++;
            @(negedge clk);
        end
        chk({nome, " latency"}, 32'(c), 32'd12);
        chk({nome, " bcd"}, 32'(bcd3), 32'(exp_bcd));
        chk({nome, " estouro"}, 32'(est3), 32'd0);
    endtask

    initial begin
        int c, o;

        tab[0] = '{8'd255, 12'h255, 3'b000};
        tab[1] = '{8'd0,   12'h000, 3'b110};
        tab[2] = '{8'd7,   12'h007, 3'b110};
        tab[3] = '{8'd42,  12'h042, 3'b100};
        tab[4] = '{8'd99,  12'h099, 3'b100};
        tab[5] = '{8'd100, 12'h100, 3'b000};
        tab[6] = '{8'd123, 12'h123, 3'b000};
        tab[7] = '{8'd201, 12'h201, 3'b000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset ocupado", 32'(ocu1), 32'd0);
        chk("reset pronto", 32'(pro1), 32'd0);
        chk("reset bcd", 32'(bcd1), 32'd0);
        chk("reset estouro", 32'(est1), 32'd0);
`ifdef BCD_APAGA_ZEROS_EN
        chk("reset apagado", 32'(apa1), 32'b110);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            conv1($sformatf("vec%0d", i), tab[i].bin, tab[i].bcd, tab[i].apag);
        end

        // inicio during conversion is ignored; bcd_out holds the previous result meanwhile
        @(negedge clk);
        inicia1(8'd123);
        repeat (2) @(negedge clk);
        bin1 = 8'd9;
        ini1 = 1'b1;
        @(negedge clk);
        ini1 = 1'b0;
        chk("hold bcd mid", 32'(bcd1), 32'h201);
        chk("ocupado mid", 32'(ocu1), 32'd1);
        espera1(c, o);
        chk("ignore latency", 32'(c), 32'd5);
        chk("ignore bcd", 32'(bcd1), 32'h123);

        // Restart in the pronto cycle (back-to-back)
        inicia1(8'd7);
        chk("b2b pronto low", 32'(pro1), 32'd0);
        espera1(c, o);
        chk("b2b latency", 32'(c), 32'd8);
        chk("b2b bcd", 32'(bcd1), 32'h007);

        // Reset mid-conversion
        @(negedge clk);
        inicia1(8'd201);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst ocupado", 32'(ocu1), 32'd0);
        chk("midrst pronto", 32'(pro1), 32'd0);
        chk("midrst bcd", 32'(bcd1), 32'd0);
        chk("midrst estouro", 32'(est1), 32'd0);
`ifdef BCD_APAGA_ZEROS_EN
        chk("midrst apagado", 32'(apa1), 32'b110);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pro1 || ocu1) c++;
        end
        chk("midrst no pronto", 32'(c), 32'd0);
        conv1("after rst", 8'd201, 12'h201, 3'b000);

        // Two-digit overflow cases
        conv2("n2 200", 8'd200, 8'h00, 1'b1);
        conv2("n2 99", 8'd99, 8'h99, 1'b0);
        conv2("n2 255", 8'd255, 8'h55, 1'b1);
        conv2("n2 100", 8'd100, 8'h00, 1'b1);

        // 12-bit, 4-digit cases
        conv3("w 4095", 12'd4095, 16'h4095);
        conv3("w 1000", 12'd1000, 16'h1000);
        conv3("w 1", 12'd1, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
